// File: rtl/dmem_responder_pkg.sv
// Shared load/store definitions for the data-memory responder: funct3 codes,
// FSM state encoding and the MMIO register address.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte/halfword/word lane steering for stores (merge into the
// old word) and loads (extract and sign/zero-extend), with legality flags.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    input  logic [31:0] rd_word,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        st_err,
    output logic        ld_err
);

    logic [31:0] shifted;

    always_comb begin
        merged = old_word;
        st_err = 1'b0;
        case (funct3)
            F3_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                st_err = addr_lo[0];
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            F3_W: begin
                st_err = (addr_lo != 2'b00);
                merged = wdata;
            end
            default: st_err = 1'b1;
        endcase
    end

    always_comb begin
        shifted = rd_word >> {addr_lo, 3'b000};
        rdata   = 32'd0;
        ld_err  = 1'b0;
        case (funct3)
            F3_B:  rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU: rdata = {24'd0, shifted[7:0]};
            F3_H: begin
                ld_err = addr_lo[0];
                rdata  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                ld_err = addr_lo[0];
                rdata  = {16'd0, shifted[15:0]};
            end
            F3_W: begin
                ld_err = (addr_lo != 2'b00);
                rdata  = rd_word;
            end
            default: ld_err = 1'b1;
        endcase
        if (ld_err) rdata = 32'd0;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request and response channels and
// programmable wait states. Define DMEM_MMIO_EN to add the mmio_out register.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_MMIO_EN
    output logic        rsp_err,
    output logic [31:0] mmio_out
`else
    output logic        rsp_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_word, merged, lane_rdata, ld_data;
    logic        st_err, ld_err, in_range, is_mmio, err, commit;

    assign in_range = (addr_q[31:2] < 30'(DEPTH_WORDS));
    assign mem_word = in_range ? mem[addr_q[AW+1:2]] : 32'd0;

    dmem_lane_align u_align (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .old_word(mem_word),
        .rd_word (mem_word),
        .merged  (merged),
        .rdata   (lane_rdata),
        .st_err  (st_err),
        .ld_err  (ld_err)
    );

`ifdef DMEM_MMIO_EN
    assign is_mmio = (addr_q == MMIO_ADDR);
    assign ld_data = is_mmio ? mmio_out : lane_rdata;
`else
    assign is_mmio = 1'b0;
    assign ld_data = lane_rdata;
`endif

    // MMIO accepts only full-word accesses and skips the range check
    assign err = is_mmio ? (f3_q != F3_W)
                         : ((we_q ? st_err : ld_err) | ~in_range);

    assign commit    = (state == ST_WAIT) && (cnt == 4'd0);
    assign req_ready = (state == ST_IDLE) && !reset;
    assign rsp_valid = (state == ST_RESP);

    // Every request spends at least one cycle in WAIT, so the commit edge
    // always works from latched fields and lands LATENCY+1 edges after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            f3_q      <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef DMEM_MMIO_EN
            mmio_out  <= 32'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    f3_q    <= req_funct3;
                    cnt     <= 4'(LATENCY);
                    state   <= ST_WAIT;
                end
                ST_WAIT: if (cnt == 4'd0) begin
                    state     <= ST_RESP;
                    rsp_err   <= err;
                    rsp_rdata <= (err || we_q) ? 32'd0 : ld_data;
`ifdef DMEM_MMIO_EN
                    if (is_mmio && we_q && !err) mmio_out <= wdata_q;
`endif
                end else begin
                    cnt <= cnt - 4'd1;
                end
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage has no reset; a reset before the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (commit && we_q && !err && !is_mmio)
            mem[addr_q[AW+1:2]] <= merged;
    end

endmodule
